// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the two-port memory bus arbiter: FSM states, port IDs,
// the captured request record and the timeout counter sizing rule.
package mem_bus_arbiter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  localparam int NUM_PORTS   = 2;
  localparam int PORT_IFETCH = 0;
  localparam int PORT_DATA   = 1;

  typedef struct packed {
    logic [31:0] address;
    logic        write;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } mem_req_t;

  // Timer is at least 8 bits wide so small TIMEOUT values still saturate cleanly.
  function automatic int timer_width(input int timeout);
    int w;
    w = $clog2(timeout + 1);
    return (w < 8) ? 8 : w;
  endfunction

endpackage

// File: rtl/mem_bus_req_latch.sv
// One-entry pending buffer for a requester: captures a request pulse and its
// fields, holds them until the arbiter grants this port.
module mem_bus_req_latch
  import mem_bus_arbiter_pkg::*;
(
  input  logic     clock,
  input  logic     reset,
  input  logic     request,
  input  logic     blocked,
  input  mem_req_t req_in,
  input  logic     grant,
  output logic     pend,
  output mem_req_t req_out
);

  always_ff @(posedge clock) begin
    if (reset) begin
      pend    <= 1'b0;
      req_out <= '0;
    end else if (grant) begin
      pend    <= 1'b0;
    end else if (request && !blocked) begin
      pend    <= 1'b1;
      req_out <= req_in;
    end
  end

  // A blocked request is dropped; the requester broke the handshake.
  ignored_request: assert property (@(posedge clock) disable iff (reset) !(request && blocked));

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one 32-bit memory bus between instruction fetch (port 0) and the
// load/store stage (port 1): one transaction in flight, response routed to its owner.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ROUND_ROBIN = 1,
  parameter int TIMEOUT     = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        p0_request,
  input  logic [31:0] p0_address,
  input  logic        p0_write,
  input  logic [3:0]  p0_wstrb,
  input  logic [31:0] p0_wdata,
  output logic [31:0] p0_rdata,
  output logic        p0_valid,
  output logic        p0_error,
  input  logic        p1_request,
  input  logic [31:0] p1_address,
  input  logic        p1_write,
  input  logic [3:0]  p1_wstrb,
  input  logic [31:0] p1_wdata,
  output logic [31:0] p1_rdata,
  output logic        p1_valid,
  output logic        p1_error,
  output logic        mem_request,
  output logic [31:0] mem_address,
  output logic        mem_write,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_valid,
  input  logic        mem_busy
);

  localparam int TW = timer_width(TIMEOUT);

  state_t                         state, state_nxt;
  logic                           owner, last_grant, winner;
  logic [TW-1:0]                  timer;
  logic [NUM_PORTS-1:0]           request, pend, grant, blocked, port_valid;
  mem_req_t [NUM_PORTS-1:0]       req_in, req_q;
  mem_req_t                       sel;
  logic                           any_pend, issue, done, timeout_hit;

  assign request             = {p1_request, p0_request};
  assign req_in[PORT_IFETCH] = '{address: p0_address, write: p0_write, wstrb: p0_wstrb, wdata: p0_wdata};
  assign req_in[PORT_DATA]   = '{address: p1_address, write: p1_write, wstrb: p1_wstrb, wdata: p1_wdata};

  // The owner may re-request only in its own completion cycle.
  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    assign blocked[i] = pend[i] || (state == ST_WAIT && owner == 1'(i) && !port_valid[i]);
    mem_bus_req_latch u_latch (
      .clock   (clock),
      .reset   (reset),
      .request (request[i]),
      .blocked (blocked[i]),
      .req_in  (req_in[i]),
      .grant   (grant[i]),
      .pend    (pend[i]),
      .req_out (req_q[i])
    );
  end

  assign any_pend = |pend;

  always_comb begin
    winner = pend[PORT_DATA];
    if (&pend) winner = (ROUND_ROBIN != 0) ? ~last_grant : 1'b1;
  end

  assign timeout_hit = (TIMEOUT != 0) && (timer == TW'(TIMEOUT - 1));

  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (any_pend && !mem_busy) state_nxt = ST_WAIT;
      ST_WAIT: if (mem_valid || timeout_hit) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Gated by reset so an aborted transaction never reports completion.
  always_comb begin
    issue = 1'b0;
    done  = 1'b0;
    case (state)
      ST_IDLE: issue = !reset && any_pend && !mem_busy;
      ST_WAIT: done  = !reset && (mem_valid || timeout_hit);
      default: ;
    endcase
  end

  assign grant      = issue ? (winner ? 2'b10 : 2'b01) : 2'b00;
  assign port_valid = done  ? (owner  ? 2'b10 : 2'b01) : 2'b00;

  always_ff @(posedge clock) begin
    if (reset) begin
      owner      <= 1'b0;
      last_grant <= 1'b0;
      timer      <= '0;
    end else if (issue) begin
      owner      <= winner;
      last_grant <= winner;
      timer      <= '0;
    end else if (state == ST_WAIT && timer != '1) begin
      timer      <= timer + TW'(1);
    end
  end

  assign sel         = req_q[issue ? winner : owner];
  assign mem_request = issue;
  assign mem_address = sel.address;
  assign mem_write   = sel.write;
  assign mem_wstrb   = sel.wstrb;
  assign mem_wdata   = sel.wdata;

  assign p0_valid = port_valid[0];
  assign p1_valid = port_valid[1];
  assign p0_error = port_valid[0] && !mem_valid;
  assign p1_error = port_valid[1] && !mem_valid;
  assign p0_rdata = (port_valid[0] && mem_valid) ? mem_rdata : '0;
  assign p1_rdata = (port_valid[1] && mem_valid) ? mem_rdata : '0;

endmodule
